// File: rtl/icache_refill_responder.sv
// rtl/icache_refill_responder.sv - icache refill responder: latency wait, aligned block burst, preload port
module icache_refill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MEM_READ_REQ,
    input  logic [ADDR_WIDTH-1:0]        MEM_ADDRESS,
    output logic                         MEM_BUSYWAIT,
    output logic [DATA_WIDTH-1:0]        MEM_READDATA,
    output logic                         MEM_READDATA_VALID,
    output logic                         MEM_ERROR,
    input  logic                         LOAD_EN,
    input  logic [$clog2(MEM_DEPTH)-1:0] LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0]        LOAD_DATA
);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

    state_t                  state, state_next;
    logic [LAT_W-1:0]        lat_cnt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [MEM_AW-1:0]       base_idx;
    logic                    base_err;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    accept;
    logic                    start_burst;
    logic                    issue;
    logic [BEAT_W-1:0]       issue_idx;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic [MEM_AW-1:0]       mem_idx;
    logic [DATA_WIDTH-1:0]   beat_word;

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        start_burst  = 1'b0;
        case (state)
            S_IDLE: begin
                if (MEM_READ_REQ) begin
                    state_next = S_WAIT;
                    accept     = 1'b1;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    state_next  = S_BURST;
                    start_burst = 1'b1;
                end
            end
            S_BURST: begin
                if (beat_cnt == LAST_BEAT) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        MEM_BUSYWAIT = (state == S_WAIT) || (state == S_BURST) ||
                       ((state == S_IDLE) && MEM_READ_REQ);
    end

    // Output registers are loaded one edge ahead, so beat k appears in the cycle it belongs to.
    assign issue        = start_burst || ((state == S_BURST) && (beat_cnt != LAST_BEAT));
    assign issue_idx    = start_burst ? '0 : beat_cnt + BEAT_W'(1);
    assign addr_aligned = MEM_ADDRESS & ~OFF_MASK;
    assign mem_idx      = base_idx | MEM_AW'(issue_idx);
    assign beat_word    = base_err ? '0 : mem[mem_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= S_IDLE;
            lat_cnt            <= '0;
            beat_cnt           <= '0;
            base_idx           <= '0;
            base_err           <= 1'b0;
            MEM_READDATA       <= '0;
            MEM_READDATA_VALID <= 1'b0;
            MEM_ERROR          <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                base_idx <= addr_aligned[MEM_AW-1:0];
                base_err <= ({1'b0, addr_aligned} >= DEPTH_EXT);
                lat_cnt  <= LAT_LOAD;
            end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (issue) begin
                beat_cnt           <= issue_idx;
                MEM_READDATA       <= beat_word;
                MEM_READDATA_VALID <= 1'b1;
                MEM_ERROR          <= base_err;
            end else if (state == S_BURST) begin
                beat_cnt           <= '0;
                MEM_READDATA_VALID <= 1'b0;
                MEM_ERROR          <= 1'b0;
            end
        end
    end

    // Storage has no reset so preloaded contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (reset && (state == S_IDLE) && LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
    end
endmodule

// File: tb/tb_icache_refill_responder.sv
// tb/tb_icache_refill_responder.sv - scoreboard bench for icache_refill_responder
module tb_icache_refill_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BS    = 4;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MEM_READ_REQ = 1'b0;
    logic [AW-1:0] MEM_ADDRESS = '0;
    logic          MEM_BUSYWAIT;
    logic [DW-1:0] MEM_READDATA;
    logic          MEM_READDATA_VALID;
    logic          MEM_ERROR;
    logic          LOAD_EN = 1'b0;
    logic [9:0]    LOAD_ADDR = '0;
    logic [DW-1:0] LOAD_DATA = '0;

    icache_refill_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .MEM_DEPTH(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .MEM_READ_REQ(MEM_READ_REQ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READDATA(MEM_READDATA),
        .MEM_READDATA_VALID(MEM_READDATA_VALID), .MEM_ERROR(MEM_ERROR),
        .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (MEM_READDATA_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_data", MEM_READDATA, b.data);
                    check("beat_error", MEM_ERROR, b.err);
                    check("beat_cycle", cyc, b.at);
                end
            end else begin
                check("error_outside_burst", MEM_ERROR, 0);
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] addr, input bit hold,
                          input bit same_load, input logic [9:0] sl_addr, input logic [DW-1:0] sl_data,
                          input bit mid_load, input bit mid_reset, output int c0);
        logic [AW-1:0] base;
        bit            err;
        @(posedge clk); #1;
        MEM_READ_REQ = 1'b1;
        MEM_ADDRESS  = addr;
        if (same_load) begin
            LOAD_EN = 1'b1; LOAD_ADDR = sl_addr; LOAD_DATA = sl_data;
        end
        @(negedge clk);
        c0 = cyc;
        check("busy_request_cycle", MEM_BUSYWAIT, 1);
        if (same_load) ref_mem[sl_addr] = sl_data;
        base = addr - (addr % BS);
        err  = (base >= DEPTH);
        for (int k = 0; k < BS; k++) begin
            beat_t b;
            b.data = err ? '0 : ref_mem[base + k];
            b.err  = err;
            b.at   = c0 + LAT + 1 + k;
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        LOAD_EN = 1'b0;
        if (!hold) MEM_READ_REQ = 1'b0;
        MEM_ADDRESS = $urandom;
        for (int i = 1; i < 40; i++) begin
            if (mid_load && i == LAT + 2) begin
                LOAD_EN = 1'b1; LOAD_ADDR = 10'($urandom); LOAD_DATA = $urandom;
            end
            if (mid_reset && i == LAT + 2) reset = 1'b0;
            @(negedge clk);
            if (mid_reset && i == LAT + 3) begin
                check("rst_valid", MEM_READDATA_VALID, 0);
                check("rst_data", MEM_READDATA, 0);
                check("rst_error", MEM_ERROR, 0);
                check("rst_busy_idle", MEM_BUSYWAIT, 0);
                exp_q.delete();
                return;
            end
            if (i < LAT + BS + 1) check("busy_held", MEM_BUSYWAIT, 1);
            if (!MEM_BUSYWAIT) break;
            @(posedge clk); #1;
            LOAD_EN = 1'b0;
            reset   = 1'b1;
        end
        check("done_cycle", cyc - c0, LAT + BS + 1);
    endtask

    initial begin
        int c_a, c_b;
        logic [AW-1:0] a;
        logic [9:0]    la;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", MEM_READDATA_VALID, 0);
        check("reset_data", MEM_READDATA, 0);
        check("reset_error", MEM_ERROR, 0);
        check("reset_busy", MEM_BUSYWAIT, 0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            LOAD_EN = 1'b1; LOAD_ADDR = 10'(i); LOAD_DATA = $urandom;
            ref_mem[i] = LOAD_DATA;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            LOAD_ADDR = 10'(32'h20 + i); LOAD_DATA = 32'hA0 + i;
            ref_mem[32'h20 + i] = LOAD_DATA;
            @(posedge clk); #1;
        end
        LOAD_EN = 1'b0;

        do_req(32'h22, 0, 0, '0, '0, 0, 0, c_a);
        do_req(32'h400, 0, 0, '0, '0, 0, 0, c_a);

        do_req(32'h1f5, 1, 0, '0, '0, 1, 0, c_a);
        do_req(32'h1f4, 0, 0, '0, '0, 0, 0, c_b);
        check("hold_reaccept_gap", c_b - c_a, LAT + BS + 2);

        do_req(32'h84, 0, 0, '0, '0, 0, 1, c_a);
        do_req(32'h22, 0, 0, '0, '0, 0, 0, c_a);

        do_req(32'h10, 0, 1, 10'h10, 32'hDEADBEEF, 0, 0, c_a);

        for (int n = 0; n < 24; n++) begin
            a  = $urandom_range(0, 1279);
            la = 10'(a - (a % BS)) + 10'($urandom_range(0, BS - 1));
            do_req(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), la, $urandom,
                   ($urandom_range(0, 2) == 0), 0, c_a);
        end
        MEM_READ_REQ = 1'b0;

        repeat (12) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for the instruction-cache refill interface. It accepts a single-word-address read request from the cache controller, holds MEM_BUSYWAIT for a programmable latency, streams one aligned block of BLOCK_SIZE words with MEM_READDATA_VALID, then signals completion. It sits between the icache controller and the instruction store. It also serves as the synthesizable backing memory for cache regression benches, with a preload port.

## Interface

- ADDR_WIDTH, 32: word-address width of MEM_ADDRESS.
- DATA_WIDTH, 32: word width.
- BLOCK_SIZE, 4: words per refill burst. Must be a power of two, ≥1.
- MEM_DEPTH, 1024: words of storage. Must be a power of two and a multiple of BLOCK_SIZE.
- LATENCY, 4: wait cycles between request acceptance and the first data beat. Range is ≥1.

Ports:

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- MEM_READ_REQ  in  1  refill request from the cache controller.
- MEM_ADDRESS  in  ADDR_WIDTH  requested word address. Low $clog2(BLOCK_SIZE) bits are ignored (forced to 0).
- MEM_BUSYWAIT  out  1  responder busy; requester must hold its request while high.
- MEM_READDATA  out  DATA_WIDTH  burst data beat (registered).
- MEM_READDATA_VALID  out  1  high for exactly BLOCK_SIZE consecutive cycles per burst (registered).
- MEM_ERROR  out  1  high during the beats of a burst whose base address is ≥ MEM_DEPTH.
- LOAD_EN  in  1  preload write strobe.
- LOAD_ADDR  in  $clog2(MEM_DEPTH)  preload word address.
- LOAD_DATA  in  DATA_WIDTH  preload data.

## Operation

- States:
  - IDLE: accepts a request when MEM_READ_REQ=1.
  - WAIT: counts LATENCY cycles.
  - BURST: issues BLOCK_SIZE beats.
  - DONE: one cycle with MEM_BUSYWAIT=0.
- Transitions:
  - IDLE→WAIT on MEM_READ_REQ=1. Captures base = MEM_ADDRESS with the low offset bits zeroed, and loads the latency counter.
  - WAIT→BURST after LATENCY cycles in WAIT.
  - BURST→DONE after beat BLOCK_SIZE-1.
  - DONE→IDLE unconditionally.
- MEM_BUSYWAIT = (state≠IDLE && state≠DONE) || (state==IDLE && MEM_READ_REQ). This combinational term ensures the requester never sees BUSYWAIT low in its first request cycle.
- Beat k (0..BLOCK_SIZE-1) carries mem[base+k]. The beat counter is $clog2(BLOCK_SIZE) bits and the last beat is at count BLOCK_SIZE-1; there is no wrap into the next block.
- Out-of-range base (≥ MEM_DEPTH): a full-length burst of zero data is issued with MEM_ERROR=1 on every beat. Timing is identical to an in-range burst.
- Request inputs are ignored in WAIT/BURST/DONE. MEM_ADDRESS changes mid-burst have no effect.
- In DONE, MEM_READ_REQ is ignored. If it is still high in the following IDLE cycle, it is treated as a new request; the requester must drop it after seeing BUSYWAIT low.
- Preload: LOAD_EN=1 writes LOAD_DATA to mem[LOAD_ADDR] only in IDLE and is ignored in all other states. A simultaneous LOAD_EN and request in IDLE performs both; the burst observes the new word.
- MEM_READDATA holds the last beat value after a burst until the next beat or reset.

## Timing

- Reset (reset=0 at an edge):
  - state→IDLE; counters→0.
  - MEM_READDATA→0, MEM_READDATA_VALID→0, MEM_ERROR→0.
  - MEM_BUSYWAIT follows the IDLE equation.
  - Memory contents are not cleared.
- Reset mid-WAIT/BURST aborts the burst. Outputs show reset values in the next cycle and no further beats are issued.
- Cycle numbering, with request accepted at edge ending cycle 0:
  - Cycles 1..LATENCY: WAIT.
  - Cycles LATENCY+1..LATENCY+BLOCK_SIZE: beats 0..BLOCK_SIZE-1, VALID=1.
  - Cycle LATENCY+BLOCK_SIZE+1: DONE, BUSYWAIT=0.
- Defaults: beats in cycles 5–8, DONE in cycle 9, earliest next acceptance in cycle 10. Request-to-request throughput is LATENCY+BLOCK_SIZE+2 cycles.
- LOAD write is visible to a read one cycle after the write edge.

## Test plan

- Preload mem[0x20..0x23]=0xA0..0xA3; request at address 0x22 → BUSYWAIT high cycles 0–8; beats 0xA0,0xA1,0xA2,0xA3 in cycles 5–8 with VALID=1; BUSYWAIT=0 in cycle 9; MEM_ERROR=0 throughout.
- Request at address 0x400 (=MEM_DEPTH) → four beats of 0x0 with MEM_ERROR=1 in cycles 5–8; same timing as an in-range burst.
- REQ held high through DONE → second burst accepted in cycle 10, with beats in cycles 15–18. Pulse LOAD_EN during BURST → memory unchanged.
- reset=0 in cycle 6 (mid-burst) → cycle 7 shows VALID=0, READDATA=0, state IDLE. A new request afterwards completes a full 4-beat burst.
- Same-cycle LOAD_EN (addr 0x10, data 0xDEADBEEF) and request at 0x10 → beat 0 = 0xDEADBEEF.
